// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// Latches the winning operation, registers the ALU result and returns it to its owner.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [SEL_W-1:0]  req0_sel,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [SEL_W-1:0]  req1_sel,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic              r_last_grant;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [SEL_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_err;
    logic              w_grant;
    logic              w_accept;
    logic              w_rsp_take;

    function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
        logic legal;
        case (sel)
            SEL_W'(4'b0000), SEL_W'(4'b0001), SEL_W'(4'b0010),
            SEL_W'(4'b0110), SEL_W'(4'b0111), SEL_W'(4'b0011): legal = 1'b1;
            default:                                           legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Round-robin grant: on contention the requester not served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end
    end

    assign w_accept   = (r_state == ST_IDLE) && (req0_valid || req1_valid);
    assign w_rsp_take = r_owner ? rsp1_ready : rsp0_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_EXEC;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: begin
                if (w_rsp_take) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RESP;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Handshake outputs; readys are masked during reset so every output reads 0.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = !rst && w_accept && !w_grant;
                req1_ready = !rst && w_accept && w_grant;
            end
            ST_EXEC: busy = 1'b1;
            ST_RESP: begin
                busy       = 1'b1;
                rsp0_valid = !r_owner;
                rsp1_valid = r_owner;
            end
            default: busy = 1'b0;
        endcase
    end

    // Operation latch, result capture and round-robin history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_op1        <= {DATA_W{1'b0}};
            r_op2        <= {DATA_W{1'b0}};
            r_sel        <= {SEL_W{1'b0}};
            r_result     <= {DATA_W{1'b0}};
            r_zero       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant;
                r_op1   <= w_grant ? req1_op1 : req0_op1;
                r_op2   <= w_grant ? req1_op2 : req0_op2;
                r_sel   <= w_grant ? req1_sel : req0_sel;
            end
            if (r_state == ST_EXEC) begin
                if (sel_legal(r_sel)) begin
                    r_result <= alu_result;
                    r_zero   <= alu_zero;
                    r_err    <= 1'b0;
                end else begin
                    r_result <= {DATA_W{1'b0}};
                    r_zero   <= 1'b1;
                    r_err    <= 1'b1;
                end
            end
            if ((r_state == ST_RESP) && w_rsp_take) begin
                r_last_grant <= r_owner;
            end
        end
    end

    assign alu_op1    = r_op1;
    assign alu_op2    = r_op2;
    assign alu_sel    = r_sel;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (32-bit operands, 4-bit select, zero flag) between two requesters, e.g. the main datapath and a multi-cycle helper unit.
- Round-robin arbitrates and latches the winning operation so the ALU inputs stay stable for a full cycle.
- Registers the ALU result and zero flag, and returns them to the owning requester over a valid/ready response channel.

Parameters:
DATA_W, 32, operand/result width; must match the ALU
SEL_W, 4, ALU select width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op1  input  DATA_W  requester 0 operand 1
req0_op2  input  DATA_W  requester 0 operand 2
req0_sel  input  SEL_W  requester 0 ALU select
rsp0_valid  output  1  result for requester 0 available
rsp0_ready  input  1  requester 0 takes the result
req1_*, rsp1_valid, rsp1_ready  same as requester 0, for requester 1
rsp_result  output  DATA_W  result, shared, qualified by rspN_valid
rsp_zero  output  1  zero flag, shared, qualified by rspN_valid
rsp_err  output  1  illegal select, qualified by rspN_valid
alu_op1  output  DATA_W  to ALU operand 1
alu_op2  output  DATA_W  to ALU operand 2
alu_sel  output  SEL_W  to ALU select
alu_result  input  DATA_W  from ALU result
alu_zero  input  1  from ALU zero flag
busy  output  1  high in EXEC or RESP

Behaviour:
- Legal selects: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 unsigned SLT, 0011 MUL (low DATA_W bits).
- Reset (async, immediate): state IDLE, last_grant=1, all outputs 0. alu_op1/alu_op2/alu_sel/rsp_result = 0, rsp_zero = 0, rsp_err = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = the requester with valid high. If both are valid, grant the one not equal to last_grant.
  - reqN_ready = grant==N, driven combinationally from the valids; at most one ready per cycle.
  - On valid&ready: latch op1, op2, sel and owner; go to EXEC.
  - With no valid: stay in IDLE; ALU ports hold their last values.
- EXEC (exactly 1 cycle):
  - ALU ports are driven from the latched registers.
  - At the clock edge, capture alu_result/alu_zero into rsp_result/rsp_zero; go to RESP.
  - If the latched sel is not a legal code: rsp_result = 0, rsp_zero = 1, rsp_err = 1, and the ALU output is ignored.
- RESP:
  - rsp<owner>_valid = 1; the other rsp valid = 0.
  - rsp_result/rsp_zero/rsp_err are held stable until rsp<owner>_ready.
  - On ready: last_grant = owner; go to IDLE. rsp valid drops the next cycle.
- Latency: request handshake in cycle N → rsp valid in cycle N+2. With ready tied high, minimum 3 cycles per operation.
- No request is accepted outside IDLE; ready stays 0 in EXEC and RESP.
- Requesters hold valid and payload stable until ready (valid must not depend on ready).
- A requester may assert a new valid while its own response is pending; it is arbitrated on return to IDLE.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- Reset during EXEC or RESP: the transaction is discarded and rsp valid drops asynchronously. The first grant after reset goes to requester 0 if both are valid.
- Response backpressure: while RESP is stalled, busy = 1 and both readys stay 0.
- Width: no extension or truncation; values pass through at DATA_W.

Test Plan:
- Single ADD: req0 op1=5, op2=7, sel=0010 → req0_ready in cycle N; rsp0_valid in N+2 with rsp_result=12, rsp_zero=0, rsp_err=0.
- Zero flag: req1 SUB op1=op2=0x0000_00FF → rsp1_valid, rsp_result=0, rsp_zero=1.
- Contention: both valid continuously, req0 AND 0xF0F0&0x0FF0, req1 SLT 3<9 → grants 0,1,0,1. Results 0x00F0 and 1 routed to the correct requester; readys never overlap.
- Backpressure: rsp0_ready held low 4 cycles → rsp0_valid and result stable, busy=1, req1_ready=0 throughout. Release → IDLE next cycle.
- Illegal sel 1111 from req0 → rsp_result=0, rsp_zero=1, rsp_err=1, regardless of alu_result.
- Async reset asserted mid-EXEC → all outputs 0 immediately, no rsp valid. After release, both valid → req0 granted first.
